axi_rd_burst: RTL and testbench

//  AXI4 read master feeding input_cache's memory port. Turns each rreq/radr line-fill request

---
 rtl/axi_rd_burst_pkg.sv | 15 +
 rtl/axi_rd_burst.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_burst.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_burst_pkg.sv
// Shared types and AXI encodings for the line-fill read master.
// No logic; constants only.
// Imported by axi_rd_burst.
package axi_rd_burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'd3;

endpackage

// File: rtl/axi_rd_burst.sv
// AXI4 read master: one line-fill request -> NBEAT/MAXLEN INCR bursts, beats returned as rack/rdata.
// Latency: ARs start 1 cycle after request; rack/rdata 1 cycle after each accepted R beat.
// Backpressure: rready held high for the whole transfer, rack has none; optional check via AXI_RD_CHK_EN.
module axi_rd_burst
    import axi_rd_burst_pkg::*;
#(
    parameter int AW     = 32,
    parameter int NBEAT  = 64,
    parameter int MAXLEN = 16
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic [AW-1:0] base,
    input  logic          rreq,
    input  logic [23:0]   radr,
    output logic          rack,
    output logic [63:0]   rdata,
    output logic          busy,
    output logic          m_arvalid,
    input  logic          m_arready,
    output logic [AW-1:0] m_araddr,
    output logic [7:0]    m_arlen,
    output logic [2:0]    m_arsize,
    output logic [1:0]    m_arburst,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [63:0]   m_rdata,
    input  logic          m_rlast,
    input  logic [1:0]    m_rresp
`ifdef AXI_RD_CHK_EN
    ,
    output logic          err,
    output logic [AW-1:0] err_adr
`endif
);

    localparam int CW = $clog2(NBEAT) + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   nadr_q, nadr_d;
    logic [CW-1:0]   arcnt_q, arcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            rack_q, rack_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            ar_hs;

`ifdef AXI_RD_CHK_EN
    localparam int BW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    logic [AW-1:0]   sadr_q, sadr_d;
    logic            err_q, err_d;
    logic [AW-1:0]   err_adr_q, err_adr_d;
    logic [CW-1:0]   beat_idx;
    logic [AW-1:0]   beat_adr;
    logic            beat_bad;
`else
    logic            unused_rsp;
    assign unused_rsp = ^{m_rresp, m_rlast};
`endif

    assign ar_hs = m_arvalid && m_arready;

    // Next-state: request latch in Idle, independent AR issue and R drain in Run
    always_comb begin
        state_d = state_q;
        nadr_d  = nadr_q;
        arcnt_d = arcnt_q;
        rcnt_d  = rcnt_q;
        rack_d  = 1'b0;
        rdata_d = rdata_q;
`ifdef AXI_RD_CHK_EN
        sadr_d    = sadr_q;
        err_d     = err_q;
        err_adr_d = err_adr_q;
        beat_idx  = CW'(NBEAT) - rcnt_q;
        beat_adr  = sadr_q + (AW'(beat_idx) << 3);
        beat_bad  = (m_rresp != RESP_OKAY) ||
                    (m_rlast != (beat_idx[BW-1:0] == BW'(MAXLEN - 1)));
`endif
        case (state_q)
            IDLE: begin
                if (rreq) begin
                    nadr_d  = base + AW'(radr);
                    arcnt_d = CW'(NBEAT / MAXLEN);
                    rcnt_d  = CW'(NBEAT);
                    state_d = RUN;
`ifdef AXI_RD_CHK_EN
                    sadr_d  = base + AW'(radr);
`endif
                end
            end
            RUN: begin
                if (ar_hs) begin
                    nadr_d  = nadr_q + AW'(MAXLEN * 8);
                    arcnt_d = arcnt_q - CW'(1);
                end
                if (m_rvalid) begin
                    rack_d  = 1'b1;
                    rdata_d = m_rdata;
                    rcnt_d  = rcnt_q - CW'(1);
                    if (rcnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
`ifdef AXI_RD_CHK_EN
                    // Only the first bad beat is recorded; the transfer carries on
                    if (beat_bad && !err_q) begin
                        err_d     = 1'b1;
                        err_adr_d = beat_adr;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
            nadr_q  <= '0;
            arcnt_q <= '0;
            rcnt_q  <= '0;
            rack_q  <= 1'b0;
            rdata_q <= '0;
`ifdef AXI_RD_CHK_EN
            sadr_q    <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            nadr_q  <= nadr_d;
            arcnt_q <= arcnt_d;
            rcnt_q  <= rcnt_d;
            rack_q  <= rack_d;
            rdata_q <= rdata_d;
`ifdef AXI_RD_CHK_EN
            sadr_q    <= sadr_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign m_arvalid = (state_q == RUN) && (arcnt_q != '0);
    assign m_araddr  = nadr_q;
    assign m_arlen   = 8'(MAXLEN - 1);
    assign m_arsize  = SIZE_8B;
    assign m_arburst = BURST_INCR;
    assign m_rready  = (state_q == RUN);
    assign rack      = rack_q;
    assign rdata     = rdata_q;
`ifdef AXI_RD_CHK_EN
    assign err       = err_q;
    assign err_adr   = err_adr_q;
`endif

endmodule

// File: tb/tb_axi_rd_burst.sv
// Randomized bench for axi_rd_burst: AXI slave model plus a transaction-level reference.
// The reference tracks outstanding ARs and beats as queues and checks every cycle.
// Build with +define+AXI_RD_CHK_EN to also check err/err_adr.
module tb_axi_rd_burst;

    localparam int AW     = 32;
    localparam int NBEAT  = 64;
    localparam int MAXLEN = 16;

    logic          clk = 1'b0;
    logic          xrst;
    logic [AW-1:0] base;
    logic          rreq;
    logic [23:0]   radr;
    logic          rack;
    logic [63:0]   rdata;
    logic          busy;
    logic          m_arvalid;
    logic          m_arready;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_rvalid;
    logic          m_rready;
    logic [63:0]   m_rdata;
    logic          m_rlast;
    logic [1:0]    m_rresp;
`ifdef AXI_RD_CHK_EN
    logic          err;
    logic [AW-1:0] err_adr;
`endif

    axi_rd_burst #(.AW(AW), .NBEAT(NBEAT), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .xrst(xrst), .base(base), .rreq(rreq), .radr(radr),
        .rack(rack), .rdata(rdata), .busy(busy),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rresp(m_rresp)
`ifdef AXI_RD_CHK_EN
        , .err(err), .err_adr(err_adr)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus knobs, written by the main sequence
    logic req_lvl;
    int   ar_stall, rv_prob, err_beat;
    bit   ar_rand;

    // reference state
    int            cyc = 0;
    bit            mdl_busy, exp_rack, clear_on_rack;
    logic [31:0]   mdl_nadr;
    int            ar_rem, rcnt, gbeat, beat_in;
    logic [63:0]   mdl_rdata;
    bit            mdl_err;
    logic [31:0]   mdl_err_adr;
    logic [31:0]   burst_q[$];
    logic [31:0]   ar_log[$];
    logic [31:0]   cur_addr;
    int            reqs_done = 0, racks_req, acc_cyc, done_cyc = 0, first_rack_cyc, last_gap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] dat(input logic [31:0] a);
        return {a ^ 32'h5A5A_A5A5, a * 32'h9E37_79B9};
    endfunction

    // Slave + reference + per-cycle compare, all on the falling edge
    initial begin
        bit busy_before;
        forever begin
            @(negedge clk);
            cyc++;
            if (!xrst) begin
                chk("rst_rack", rack, 0);
                chk("rst_busy", busy, 0);
                chk("rst_arvalid", m_arvalid, 0);
                chk("rst_rready", m_rready, 0);
                chk("rst_rdata", rdata, 0);
`ifdef AXI_RD_CHK_EN
                chk("rst_err", err, 0);
                chk("rst_err_adr", err_adr, 0);
`endif
                mdl_busy = 0; exp_rack = 0; clear_on_rack = 0; mdl_rdata = '0;
                mdl_err = 0; mdl_err_adr = '0; ar_rem = 0; rcnt = 0; beat_in = 0;
                burst_q.delete();
                rreq = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rdata = '0;
                continue;
            end
            // outputs produced by the previous rising edge
            chk("rack", rack, exp_rack);
            chk("rdata", rdata, mdl_rdata);
            chk("busy", busy, mdl_busy);
            chk("rready", m_rready, mdl_busy);
            chk("arvalid", m_arvalid, mdl_busy && ar_rem > 0);
            if (mdl_busy && ar_rem > 0) begin
                chk("araddr", m_araddr, mdl_nadr);
                chk("arlen", m_arlen, MAXLEN - 1);
                chk("arsize", m_arsize, 3);
                chk("arburst", m_arburst, 1);
            end
`ifdef AXI_RD_CHK_EN
            chk("err", err, mdl_err);
            chk("err_adr", err_adr, mdl_err_adr);
`endif
            if (exp_rack) begin
                racks_req++;
                if (first_rack_cyc < 0) first_rack_cyc = cyc;
                if (clear_on_rack) begin
                    req_lvl = 0;
                    clear_on_rack = 0;
                end
            end
            // drive inputs for the next rising edge
            rreq = req_lvl;
            m_arready = (cyc - acc_cyc >= ar_stall) && (!ar_rand || $urandom_range(0, 1) == 1);
            if (burst_q.size() > 0 && (rv_prob >= 100 || $urandom_range(0, 99) < rv_prob)) begin
                cur_addr = burst_q[0] + 32'(beat_in * 8);
                m_rvalid = 1;
                m_rdata  = dat(cur_addr);
                m_rlast  = (beat_in == MAXLEN - 1);
                m_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_rvalid = 0;
                m_rdata  = {$urandom, $urandom};
                m_rlast  = $urandom_range(0, 1) == 1;
                m_rresp  = 2'($urandom_range(0, 3));
            end
            // what the next rising edge must do
            busy_before = mdl_busy;
            exp_rack = 0;
            if (mdl_busy && ar_rem > 0 && m_arready) begin
                ar_log.push_back(mdl_nadr);
                burst_q.push_back(mdl_nadr);
                mdl_nadr = mdl_nadr + 32'(MAXLEN * 8);
                ar_rem--;
            end
            if (mdl_busy && m_rvalid) begin
                exp_rack = 1;
                mdl_rdata = m_rdata;
                if (m_rresp != 2'b00 && !mdl_err) begin
                    mdl_err = 1;
                    mdl_err_adr = cur_addr;
                end
                gbeat++;
                beat_in++;
                if (beat_in == MAXLEN) begin
                    beat_in = 0;
                    void'(burst_q.pop_front());
                end
                rcnt--;
                if (rcnt == 0) begin
                    mdl_busy = 0;
                    reqs_done++;
                    done_cyc = cyc;
                end
            end
            if (!busy_before && rreq) begin
                mdl_busy = 1;
                mdl_nadr = base + {8'h00, radr};
                ar_rem = NBEAT / MAXLEN;
                rcnt = NBEAT;
                gbeat = 0;
                last_gap = cyc - done_cyc;
                acc_cyc = cyc;
                clear_on_rack = 1;
                racks_req = 0;
                first_rack_cyc = -1;
            end
        end
    end

    task automatic wait_done(input int target, input string nm);
        int i = 0;
        while (reqs_done < target && i < 3000) begin
            @(posedge clk);
            i++;
        end
        chk(nm, reqs_done >= target, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] b, input logic [23:0] r, input int stall,
                          input bit arr, input int prob, input int ebeat, input string nm);
        int target;
        @(posedge clk);
        #1;
        base = b; radr = r; ar_stall = stall; ar_rand = arr; rv_prob = prob; err_beat = ebeat;
        ar_log.delete();
        target = reqs_done + 1;
        req_lvl = 1;
        wait_done(target, nm);
        chk({nm, "_racks"}, racks_req, NBEAT);
    endtask

    initial begin
        logic [31:0] exp_ar [4];
        int t, i;
        xrst = 0; req_lvl = 0; base = '0; radr = '0;
        ar_stall = 0; ar_rand = 0; rv_prob = 100; err_beat = -1;
        repeat (3) @(posedge clk);
        #2 xrst = 1;

        // 1: basic line fill, everything ready
        exp_ar = '{32'h1000_0200, 32'h1000_0280, 32'h1000_0300, 32'h1000_0380};
        do_req(32'h1000_0000, 24'h200, 0, 0, 100, -1, "t1");
        chk("t1_ar_count", ar_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("t1_araddr", ar_log.size() > k ? ar_log[k] : 32'hX, exp_ar[k]);
        chk("t1_turnaround_le67", (done_cyc - acc_cyc) <= 67, 1);

        // 2: AR channel stalled 20 cycles
        do_req(32'h1000_0000, 24'h200, 20, 0, 100, -1, "t2");
        chk("t2_first_rack_after_stall", (first_rack_cyc - acc_cyc) > 20, 1);
        chk("t2_araddr0", ar_log.size() > 0 ? ar_log[0] : 32'hX, 32'h1000_0200);

        // 3: random rvalid and arready
        do_req(32'h2000_0000, 24'h1600, 0, 1, 50, -1, "t3");

        // 4: rreq re-asserted during Run, picked up on the Idle cycle
        @(posedge clk);
        #1;
        base = 32'h1000_0000; radr = 24'h200; ar_stall = 0; ar_rand = 0; rv_prob = 100; err_beat = -1;
        ar_log.delete();
        t = reqs_done;
        req_lvl = 1;
        i = 0;
        while (req_lvl && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        radr = 24'h400;
        req_lvl = 1;
        wait_done(t + 2, "t4_done");
        chk("t4_ar_count", ar_log.size(), 8);
        chk("t4_second_ar", ar_log.size() > 4 ? ar_log[4] : 32'hX, 32'h1000_0400);
        chk("t4_rearm_gap", last_gap, 1);
        chk("t4_racks", racks_req, NBEAT);

        // 6: SLVERR on beat 5 (flag only exists with the check build)
        do_req(32'h1000_0000, 24'h200, 0, 0, 100, 5, "t6");
`ifdef AXI_RD_CHK_EN
        chk("t6_err", err, 1);
        chk("t6_err_adr", err_adr, 32'h1000_0228);
`endif

        // 5: asynchronous reset mid-line, then a fresh request
        @(posedge clk);
        #1;
        base = 32'h3000_0000; radr = 24'h0; ar_stall = 0; ar_rand = 0; rv_prob = 100; err_beat = -1;
        req_lvl = 1;
        i = 0;
        while (!(mdl_busy && racks_req >= 30) && i < 500) begin
            @(posedge clk);
            i++;
        end
        chk("t5_reached_beat30", racks_req >= 30, 1);
        #2 xrst = 0;
        req_lvl = 0;
        #1;
        chk("t5_async_rack", rack, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_arvalid", m_arvalid, 0);
        chk("t5_async_rready", m_rready, 0);
        chk("t5_async_rdata", rdata, 0);
`ifdef AXI_RD_CHK_EN
        chk("t5_async_err", err, 0);
`endif
        repeat (3) @(posedge clk);
        #2 xrst = 1;
        do_req(32'h3000_0000, 24'h800, 0, 0, 100, -1, "t5_after");

        // address wrap modulo 2^32
        do_req(32'hFFFF_FE00, 24'h200, 0, 0, 100, -1, "wrap");
        chk("wrap_araddr0", ar_log.size() > 0 ? ar_log[0] : 32'hX, 32'h0000_0000);

        // random lines
        for (int n = 0; n < 6; n++)
            do_req({$urandom_range(0, 32'h7F_FFFF), 9'h0}, {15'($urandom), 9'h0},
                   $urandom_range(0, 5), $urandom_range(0, 1) == 1, $urandom_range(30, 100),
                   -1, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
